// File: rtl/player_motion_ctrl_if.sv
// Player motion controller bus: keyboard/player-state inputs, level-grid probe
// port and committed player-state outputs.
//   master : environment side (keyboard decoder, renderer, level-grid RAM)
//   slave  : player_motion_ctrl
// Signals:
//   start, turn_right, turn_left, move_fwd, move_back   update request and keys
//   cur_pos_x/y, cur_angle, dir_x/y                     current player state + step
//   grid_x/y, grid_req, grid_out                        level-grid probe port
//   next_pos_x/y, next_angle, blocked, busy, done       committed state and status
interface player_motion_ctrl_if #(
    parameter int unsigned X_W    = 18,
    parameter int unsigned Y_W    = 17,
    parameter int unsigned ANG_W  = 8,
    parameter int unsigned GX_W   = 6,
    parameter int unsigned GY_W   = 5,
    parameter int unsigned CELL_W = 3
);
    logic              start;
    logic              turn_right;
    logic              turn_left;
    logic              move_fwd;
    logic              move_back;
    logic [X_W-1:0]    cur_pos_x;
    logic [Y_W-1:0]    cur_pos_y;
    logic [ANG_W-1:0]  cur_angle;
    logic [X_W-1:0]    dir_x;
    logic [Y_W-1:0]    dir_y;
    logic [GX_W-1:0]   grid_x;
    logic [GY_W-1:0]   grid_y;
    logic              grid_req;
    logic [CELL_W-1:0] grid_out;
    logic [X_W-1:0]    next_pos_x;
    logic [Y_W-1:0]    next_pos_y;
    logic [ANG_W-1:0]  next_angle;
    logic              blocked;
    logic              busy;
    logic              done;

    modport master (
        output start, turn_right, turn_left, move_fwd, move_back,
        output cur_pos_x, cur_pos_y, cur_angle, dir_x, dir_y,
        output grid_out,
        input  grid_x, grid_y, grid_req,
        input  next_pos_x, next_pos_y, next_angle, blocked, busy, done
    );

    modport slave (
        input  start, turn_right, turn_left, move_fwd, move_back,
        input  cur_pos_x, cur_pos_y, cur_angle, dir_x, dir_y,
        input  grid_out,
        output grid_x, grid_y, grid_req,
        output next_pos_x, next_pos_y, next_angle, blocked, busy, done
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion controller for the raycaster datapath.
// On a rate-limited start it turns and translates the player, probing the
// level grid for walls; with PLAYER_SLIDE_EN defined, a blocked diagonal move
// retries along x only, then y only (wall slide).
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous, active-high reset
//   bus    player_motion_ctrl_if.slave (keys, current state, grid probe, results)
// Configuration macro: PLAYER_SLIDE_EN
module player_motion_ctrl #(
    parameter int unsigned X_W        = 18,
    parameter int unsigned Y_W        = 17,
    parameter int unsigned ANG_W      = 8,
    parameter int unsigned TILE_SHIFT = 12,
    parameter int unsigned GX_W       = 6,
    parameter int unsigned GY_W       = 5,
    parameter int unsigned GRID_COLS  = 40,
    parameter int unsigned GRID_ROWS  = 30,
    parameter int unsigned CELL_W     = 3,
    parameter int unsigned TURN_STEP  = 10,
    parameter int unsigned TICK_W     = 20,
    parameter int unsigned SPAWN_X    = 32'h0000_8000,
    parameter int unsigned SPAWN_Y    = 32'h0000_8000,
    parameter int unsigned SPAWN_ANG  = 0
) (
    input logic                clk_i,
    input logic                rst_i,
    player_motion_ctrl_if.slave bus
);

    localparam int unsigned XI_W = X_W - TILE_SHIFT;
    localparam int unsigned YI_W = Y_W - TILE_SHIFT;

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_P0, S_C0, S_P1, S_C1, S_P2, S_C2, S_COMMIT, S_DONE
    } state_t;

    state_t            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [X_W-1:0]    sx_q, tx_q, cand_x_q, commit_x_q, next_x_q;
    logic [Y_W-1:0]    sy_q, ty_q, cand_y_q, commit_y_q, next_y_q;
    logic [ANG_W-1:0]  new_ang_q, next_ang_q;
    logic [GX_W-1:0]   grid_x_q;
    logic [GY_W-1:0]   grid_y_q;
    logic              grid_req_q, oob_q, blk_q, blocked_q, busy_q, done_q;

    logic              key_r, key_l, key_f, key_b, mv_d;
    logic [ANG_W-1:0]  new_angle_d;
    logic [X_W-1:0]    tx_d, probe_x_d;
    logic [Y_W-1:0]    ty_d, probe_y_d;
    logic [XI_W-1:0]   probe_ix;
    logic [YI_W-1:0]   probe_iy;
    logic              probe_oob_d;
    logic              free_c;

    // Key decode and target computation from the live inputs (used in CALC only)
    always_comb begin
        key_r       = bus.turn_right && !bus.turn_left;
        key_l       = bus.turn_left  && !bus.turn_right;
        key_f       = bus.move_fwd   && !bus.move_back;
        key_b       = bus.move_back  && !bus.move_fwd;
        mv_d        = key_f || key_b;
        new_angle_d = bus.cur_angle;
        tx_d        = bus.cur_pos_x;
        ty_d        = bus.cur_pos_y;
        if (key_r) begin
            new_angle_d = bus.cur_angle + ANG_W'(TURN_STEP);
        end else if (key_l) begin
            new_angle_d = bus.cur_angle - ANG_W'(TURN_STEP);
        end
        if (key_f) begin
            tx_d = bus.cur_pos_x + bus.dir_x;
            ty_d = bus.cur_pos_y + bus.dir_y;
        end else if (key_b) begin
            tx_d = bus.cur_pos_x - bus.dir_x;
            ty_d = bus.cur_pos_y - bus.dir_y;
        end
    end

    // Candidate for the probe launched on leaving the current state
    always_comb begin
        case (state_q)
            S_CALC: begin
                probe_x_d = tx_d;
                probe_y_d = ty_d;
            end
            S_C0: begin
                probe_x_d = tx_q;
                probe_y_d = sy_q;
            end
            S_C1: begin
                probe_x_d = sx_q;
                probe_y_d = ty_q;
            end
            default: begin
                probe_x_d = tx_q;
                probe_y_d = ty_q;
            end
        endcase
        probe_ix    = XI_W'(probe_x_d >> TILE_SHIFT);
        probe_iy    = YI_W'(probe_y_d >> TILE_SHIFT);
        // Range check on the full tile index so out-of-map cells read as wall
        probe_oob_d = (32'(probe_ix) >= GRID_COLS) || (32'(probe_iy) >= GRID_ROWS);
    end

    assign free_c = (bus.grid_out == '0) && !oob_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            commit_x_q <= '0;
            commit_y_q <= '0;
            new_ang_q  <= '0;
            next_x_q   <= X_W'(SPAWN_X);
            next_y_q   <= Y_W'(SPAWN_Y);
            next_ang_q <= ANG_W'(SPAWN_ANG);
            grid_x_q   <= '0;
            grid_y_q   <= '0;
            grid_req_q <= 1'b0;
            oob_q      <= 1'b0;
            blk_q      <= 1'b0;
            blocked_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q     <= tick_q + TICK_W'(1);
            done_q     <= 1'b0;
            grid_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (tick_q == '0)) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                S_CALC: begin
                    sx_q      <= bus.cur_pos_x;
                    sy_q      <= bus.cur_pos_y;
                    tx_q      <= tx_d;
                    ty_q      <= ty_d;
                    new_ang_q <= new_angle_d;
                    if (mv_d) begin
                        grid_x_q   <= GX_W'(probe_ix);
                        grid_y_q   <= GY_W'(probe_iy);
                        grid_req_q <= 1'b1;
                        oob_q      <= probe_oob_d;
                        cand_x_q   <= probe_x_d;
                        cand_y_q   <= probe_y_d;
                        state_q    <= S_P0;
                    end else begin
                        commit_x_q <= bus.cur_pos_x;
                        commit_y_q <= bus.cur_pos_y;
                        blk_q      <= 1'b0;
                        state_q    <= S_COMMIT;
                    end
                end
                S_P0: state_q <= S_C0;
                S_C0: begin
                    if (free_c) begin
                        commit_x_q <= cand_x_q;
                        commit_y_q <= cand_y_q;
                        blk_q      <= 1'b0;
                        state_q    <= S_COMMIT;
                    end else begin
`ifdef PLAYER_SLIDE_EN
                        grid_x_q   <= GX_W'(probe_ix);
                        grid_y_q   <= GY_W'(probe_iy);
                        grid_req_q <= 1'b1;
                        oob_q      <= probe_oob_d;
                        cand_x_q   <= probe_x_d;
                        cand_y_q   <= probe_y_d;
                        state_q    <= S_P1;
`else
                        commit_x_q <= sx_q;
                        commit_y_q <= sy_q;
                        blk_q      <= 1'b1;
                        state_q    <= S_COMMIT;
`endif
                    end
                end
`ifdef PLAYER_SLIDE_EN
                S_P1: state_q <= S_C1;
                S_C1: begin
                    if (free_c) begin
                        commit_x_q <= cand_x_q;
                        commit_y_q <= cand_y_q;
                        blk_q      <= 1'b0;
                        state_q    <= S_COMMIT;
                    end else begin
                        grid_x_q   <= GX_W'(probe_ix);
                        grid_y_q   <= GY_W'(probe_iy);
                        grid_req_q <= 1'b1;
                        oob_q      <= probe_oob_d;
                        cand_x_q   <= probe_x_d;
                        cand_y_q   <= probe_y_d;
                        state_q    <= S_P2;
                    end
                end
                S_P2: state_q <= S_C2;
                S_C2: begin
                    // Last chance: fall back to the snapshot if still walled
                    commit_x_q <= free_c ? cand_x_q : sx_q;
                    commit_y_q <= free_c ? cand_y_q : sy_q;
                    blk_q      <= !free_c;
                    state_q    <= S_COMMIT;
                end
`endif
                S_COMMIT: begin
                    next_x_q   <= commit_x_q;
                    next_y_q   <= commit_y_q;
                    next_ang_q <= new_ang_q;
                    blocked_q  <= blk_q;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grid_x     = grid_x_q;
    assign bus.grid_y     = grid_y_q;
    assign bus.grid_req   = grid_req_q;
    assign bus.next_pos_x = next_x_q;
    assign bus.next_pos_y = next_y_q;
    assign bus.next_angle = next_ang_q;
    assign bus.blocked    = blocked_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed testbench for player_motion_ctrl (rate counter shortened to 4 bits).
module tb_player_motion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    player_motion_ctrl_if bus_if ();

    player_motion_ctrl #(.TICK_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Independent model of the free-running rate counter
    logic [3:0] tb_tick;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_tick <= '0;
        else     tb_tick <= tb_tick + 4'd1;
    end

    // Level-grid RAM model: one wall cell, one-cycle registered read
    logic [5:0] wall_x = '0;
    logic [4:0] wall_y = '0;
    bit         wall_on = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) bus_if.grid_out <= '0;
        else if (bus_if.grid_req)
            bus_if.grid_out <= (wall_on && bus_if.grid_x == wall_x && bus_if.grid_y == wall_y)
                               ? 3'd5 : 3'd0;
    end

    // Probe address observed during P0 of the last fire
    logic [5:0] gx_p0;
    logic [4:0] gy_p0;
    logic       req_p0;

    task automatic set_in(input logic [17:0] px, input logic [16:0] py, input logic [7:0] ang,
                          input logic [17:0] dx, input logic [16:0] dy,
                          input bit r, input bit l, input bit f, input bit b);
        bus_if.cur_pos_x  = px;
        bus_if.cur_pos_y  = py;
        bus_if.cur_angle  = ang;
        bus_if.dir_x      = dx;
        bus_if.dir_y      = dy;
        bus_if.turn_right = r;
        bus_if.turn_left  = l;
        bus_if.move_fwd   = f;
        bus_if.move_back  = b;
    endtask

    // Start one update on a tick==0 edge; lat = edges from acceptance to done
    task automatic fire(output int lat, output int pulses, output bit req_seen);
        lat = -1;
        pulses = 0;
        req_seen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40 && tb_tick != 4'd0; i++) @(negedge clk);
        bus_if.start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus_if.start = 1'b0;
            if (k == 2) begin
                gx_p0  = bus_if.grid_x;
                gy_p0  = bus_if.grid_y;
                req_p0 = bus_if.grid_req;
            end
            if (bus_if.grid_req) req_seen = 1'b1;
            if (bus_if.done) begin
                pulses++;
                if (lat < 0) lat = k - 1;
            end
        end
    endtask

    task automatic test_reset();
        #23;
        n_checks++; if (bus_if.next_pos_x !== 18'h08000) $display("FAIL rst_x: got %h want 08000", bus_if.next_pos_x); else n_pass++;
        n_checks++; if (bus_if.next_pos_y !== 17'h08000) $display("FAIL rst_y: got %h want 08000", bus_if.next_pos_y); else n_pass++;
        n_checks++; if ({bus_if.done, bus_if.busy, bus_if.grid_req, bus_if.blocked} !== 4'b0)
            $display("FAIL rst_flags: got %b want 0000", {bus_if.done, bus_if.busy, bus_if.grid_req, bus_if.blocked}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fwd();
        int lat, pulses;
        bit req;
        set_in(18'h08000, 17'h08000, 8'd0, 18'h00100, 17'h0, 0, 0, 1, 0);
        fire(lat, pulses, req);
        n_checks++; if (lat !== 4) $display("FAIL fwd_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL fwd_pulse: got %0d want 1", pulses); else n_pass++;
        n_checks++; if ({req_p0, gx_p0, gy_p0} !== {1'b1, 6'd8, 5'd8})
            $display("FAIL fwd_probe: got req=%b gx=%0d gy=%0d want 1 8 8", req_p0, gx_p0, gy_p0); else n_pass++;
        n_checks++; if (bus_if.next_pos_x !== 18'h08100) $display("FAIL fwd_x: got %h want 08100", bus_if.next_pos_x); else n_pass++;
        n_checks++; if (bus_if.next_pos_y !== 17'h08000) $display("FAIL fwd_y: got %h want 08000", bus_if.next_pos_y); else n_pass++;
        n_checks++; if (bus_if.next_angle !== 8'd0) $display("FAIL fwd_ang: got %0d want 0", bus_if.next_angle); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL fwd_busy: got %b want 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_slide();
        int lat, pulses;
        bit req;
        wall_x = 6'd9; wall_y = 5'd9; wall_on = 1'b1;
        set_in(18'h08000, 17'h08000, 8'd0, 18'h01000, 17'h01000, 0, 0, 1, 0);
        fire(lat, pulses, req);
        wall_on = 1'b0;
`ifdef PLAYER_SLIDE_EN
        n_checks++; if (lat !== 6) $display("FAIL slide_lat: got %0d want 6", lat); else n_pass++;
        n_checks++; if (bus_if.next_pos_x !== 18'h09000) $display("FAIL slide_x: got %h want 09000", bus_if.next_pos_x); else n_pass++;
        n_checks++; if (bus_if.blocked !== 1'b0) $display("FAIL slide_blk: got %b want 0", bus_if.blocked); else n_pass++;
`else
        n_checks++; if (lat !== 4) $display("FAIL slide_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if (bus_if.next_pos_x !== 18'h08000) $display("FAIL slide_x: got %h want 08000", bus_if.next_pos_x); else n_pass++;
        n_checks++; if (bus_if.blocked !== 1'b1) $display("FAIL slide_blk: got %b want 1", bus_if.blocked); else n_pass++;
`endif
        n_checks++; if (bus_if.next_pos_y !== 17'h08000) $display("FAIL slide_y: got %h want 08000", bus_if.next_pos_y); else n_pass++;
    endtask

    task automatic test_turn();
        int lat, pulses;
        bit req;
        set_in(18'h05000, 17'h06000, 8'd5, 18'h00100, 17'h00100, 0, 1, 0, 0);
        fire(lat, pulses, req);
        n_checks++; if (lat !== 2) $display("FAIL turn_lat: got %0d want 2", lat); else n_pass++;
        n_checks++; if (req !== 1'b0) $display("FAIL turn_req: got %b want 0", req); else n_pass++;
        n_checks++; if (bus_if.next_angle !== 8'd251) $display("FAIL turn_ang: got %0d want 251", bus_if.next_angle); else n_pass++;
        n_checks++; if ({bus_if.next_pos_x, bus_if.next_pos_y} !== {18'h05000, 17'h06000})
            $display("FAIL turn_pos: got %h,%h want 05000,06000", bus_if.next_pos_x, bus_if.next_pos_y); else n_pass++;
        n_checks++; if (bus_if.blocked !== 1'b0) $display("FAIL turn_blk: got %b want 0", bus_if.blocked); else n_pass++;
    endtask

    task automatic test_back();
        int lat, pulses;
        bit req;
        set_in(18'h08000, 17'h08000, 8'd250, 18'h00100, 17'h00100, 1, 0, 0, 1);
        fire(lat, pulses, req);
        n_checks++; if (lat !== 4) $display("FAIL back_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if ({bus_if.next_pos_x, bus_if.next_pos_y} !== {18'h07F00, 17'h07F00})
            $display("FAIL back_pos: got %h,%h want 07f00,07f00", bus_if.next_pos_x, bus_if.next_pos_y); else n_pass++;
        n_checks++; if (bus_if.next_angle !== 8'd4) $display("FAIL back_ang: got %0d want 4", bus_if.next_angle); else n_pass++;
    endtask

    task automatic test_oob();
        int lat, pulses;
        bit req;
        set_in(18'h27800, 17'h08000, 8'd9, 18'h01000, 17'h0, 0, 0, 1, 0);
        fire(lat, pulses, req);
        n_checks++; if ({bus_if.next_pos_x, bus_if.next_pos_y} !== {18'h27800, 17'h08000})
            $display("FAIL oob_pos: got %h,%h want 27800,08000", bus_if.next_pos_x, bus_if.next_pos_y); else n_pass++;
`ifdef PLAYER_SLIDE_EN
        n_checks++; if (lat !== 8) $display("FAIL oob_lat: got %0d want 8", lat); else n_pass++;
        n_checks++; if (bus_if.blocked !== 1'b0) $display("FAIL oob_blk: got %b want 0", bus_if.blocked); else n_pass++;
`else
        n_checks++; if (lat !== 4) $display("FAIL oob_lat: got %0d want 4", lat); else n_pass++;
        n_checks++; if (bus_if.blocked !== 1'b1) $display("FAIL oob_blk: got %b want 1", bus_if.blocked); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int pulses = 0;
        set_in(18'h01234, 17'h02345, 8'd77, 18'h00100, 17'h00100, 1, 1, 1, 1);
        @(negedge clk);
        for (int i = 0; i < 40 && tb_tick != 4'd0; i++) @(negedge clk);
        bus_if.start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) pulses++;
            if (bus_if.done !== ((k >= 3) && ((k - 3) % 16 == 0))) bad++;
        end
        bus_if.start = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL retrig_timing: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (pulses !== 3) $display("FAIL retrig_pulses: got %0d want 3", pulses); else n_pass++;
        n_checks++; if ({bus_if.next_pos_x, bus_if.next_pos_y, bus_if.next_angle} !== {18'h01234, 17'h02345, 8'd77})
            $display("FAIL retrig_state: got %h,%h,%0d want 01234,02345,77",
                     bus_if.next_pos_x, bus_if.next_pos_y, bus_if.next_angle); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        set_in(18'h08000, 17'h08000, 8'd0, 18'h00100, 17'h0, 0, 0, 1, 0);
        @(negedge clk);
        for (int i = 0; i < 40 && tb_tick != 4'd0; i++) @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (bus_if.grid_req !== 1'b1) $display("FAIL mid_in_p0: got %b want 1", bus_if.grid_req); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({bus_if.next_pos_x, bus_if.next_pos_y, bus_if.next_angle} !== {18'h08000, 17'h08000, 8'd0})
            $display("FAIL mid_spawn: got %h,%h,%0d want 08000,08000,0",
                     bus_if.next_pos_x, bus_if.next_pos_y, bus_if.next_angle); else n_pass++;
        n_checks++; if ({bus_if.grid_req, bus_if.busy, bus_if.done, bus_if.grid_x} !== 9'b0)
            $display("FAIL mid_flags: got req=%b busy=%b done=%b gx=%0d want 0",
                     bus_if.grid_req, bus_if.busy, bus_if.done, bus_if.grid_x); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL mid_nodone: got %0d pulses want 0", pulses); else n_pass++;
    endtask

    initial begin
        bus_if.start = 1'b0;
        set_in(18'h0, 17'h0, 8'd0, 18'h0, 17'h0, 0, 0, 0, 0);
        test_reset();
        test_fwd();
        test_slide();
        test_turn();
        test_back();
        test_oob();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
